demux_8_steer: RTL

- Registered 1-to-2 demultiplexer for the adder datapath.
- Takes one WIDTH-bit operand/result stream and routes each word to one of two output channels, chosen by a per-word select bit.
- Each channel has a one-entry holding register with valid/ready flow control, so a stalled destination does not block the other channel.
- Per-channel delivery counters support debug and checking.

---
 rtl/demux_8_steer.sv | 111 +++++++++++
 1 files changed

// File: rtl/demux_8_steer.sv
// Registered 1-to-2 demultiplexer: routes each input word to one of two
// one-entry output channels with independent valid/ready flow control.
module demux_8_steer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t        st_p0  [2];
  ch_state_t        st_nxt [2];
  logic [WIDTH-1:0] data_p0 [2];
  logic [CNT_W-1:0] cnt_p0  [2];

  logic [1:0] vld_p0;
  logic [1:0] rdy;
  logic [1:0] drain;
  logic [1:0] load;
  logic       accept;

  // Delivery counters wrap silently; no saturation is wanted.
  function automatic logic [CNT_W-1:0] cnt_wrap_inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(1);
  endfunction

  assign vld_p0[0] = (st_p0[0] == FULL);
  assign vld_p0[1] = (st_p0[1] == FULL);
  assign rdy       = {out1_ready, out0_ready};
  assign drain     = vld_p0 & rdy;

  // Ready looks only at the selected channel, so a stalled channel never
  // blocks traffic headed for the other one.
  assign in_ready  = ~vld_p0[in_sel] | rdy[in_sel];
  assign accept    = in_valid & in_ready;
  assign load      = {accept & in_sel, accept & ~in_sel};

  // Input -> holding register boundary (p0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_p0[i] <= EMPTY;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_p0[i] <= st_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_nxt[i] = st_p0[i];
      case (st_p0[i])
        EMPTY: if (load[i]) st_nxt[i] = FULL;
        FULL:  if (drain[i] && !load[i]) st_nxt[i] = EMPTY;
        default: st_nxt[i] = EMPTY;
      endcase
    end
  end

  // Data only moves on a load, so idle or X-valued input never reaches outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) data_p0[i] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cnt_p0[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (drain[i]) cnt_p0[i] <= cnt_wrap_inc(cnt_p0[i]);
      end
    end
  end

  assign out0_data  = data_p0[0];
  assign out1_data  = data_p0[1];
  assign out0_valid = vld_p0[0];
  assign out1_valid = vld_p0[1];
  assign cnt0       = cnt_p0[0];
  assign cnt1       = cnt_p0[1];

endmodule
